byte_packer: RTL and testbench

- Downstream neighbour of the 8-bit valid/ready register slice. Consumes its byte stream and packs consecutive bytes into BYTES-wide words.
- Each emitted word carries a byte-keep mask and a last flag, so a short final word can be marked.
- Two word-level buffers (assembly and output) let the block sustain one byte per cycle with no bubbles while down_ready is high.
- It also absorbs one full word of downstream backpressure before stalling upstream.

---
 rtl/handshake_pkg.sv | 35 +++
 rtl/word_slot.sv | 56 +++++
 rtl/byte_packer.sv | 147 ++++++++++++++
 tb/tb_byte_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the byte-stream width converters: byte width and
// helpers for building keep masks and writing a byte into a word lane.
package handshake_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_LANES = 16;
    localparam int MAX_W     = BYTE_W * MAX_LANES;

    // Contiguous keep mask with lanes 0..n set.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i <= n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Return word with lane 'lane' replaced by byte b; other lanes untouched.
    function automatic logic [MAX_W-1:0] lane_write(input logic [MAX_W-1:0] word,
                                                    input int lane,
                                                    input logic [BYTE_W-1:0] b);
        logic [MAX_W-1:0] w;
        w = word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i == lane) begin
                w[i*BYTE_W +: BYTE_W] = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/word_slot.sv
// One word-wide holding register (data, keep, last, valid). Load takes the
// inputs wholesale, clear empties the slot, drain only drops valid so the
// data stays put.
module word_slot
    import handshake_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      clear_i,
    input  logic                      drain_i,
    input  logic [BYTE_W*LANES-1:0]   data_i,
    input  logic [LANES-1:0]          keep_i,
    input  logic                      last_i,
    input  logic                      valid_i,
    output logic [BYTE_W*LANES-1:0]   data_o,
    output logic [LANES-1:0]          keep_o,
    output logic                      last_o,
    output logic                      valid_o
);

    logic [BYTE_W*LANES-1:0] data_q;
    logic [LANES-1:0]        keep_q;
    logic                    last_q;
    logic                    valid_q;

    // Slot register: load has priority over clear, clear over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
            valid_q <= valid_i;
        end else if (clear_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream into BYTES-wide little-endian words with a
// keep mask and last flag. An assembly slot collects bytes and can hold one
// finished word while the output slot is stalled; the output slot drives
// the downstream port directly.
module byte_packer
    import handshake_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BYTE_W-1:0]       up_data,
    input  logic                    up_valid,
    input  logic                    up_last,
    output logic                    up_ready,
    output logic [BYTE_W*BYTES-1:0] down_data,
    output logic [BYTES-1:0]        down_keep,
    output logic                    down_last,
    output logic                    down_valid,
    input  logic                    down_ready
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DW    = BYTE_W * BYTES;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DW-1:0]    asmData;
    logic [BYTES-1:0] asmKeep;
    logic             asmLast;
    logic             asmFull;

    logic             outValid;

    logic             accept;
    logic             wordDone;
    logic             outFree;
    logic [DW-1:0]    doneData;
    logic [BYTES-1:0] doneKeep;

    logic             asmLoad, asmClear, asmValidIn, asmLastIn;
    logic             outLoad, outDrain;
    logic [DW-1:0]    outDataIn;
    logic [BYTES-1:0] outKeepIn;
    logic             outLastIn;

    assign up_ready = ~asmFull;
    assign accept   = up_valid & up_ready;
    assign wordDone = accept & ((cnt_q == CNT_W'(BYTES-1)) | up_last);
    assign outFree  = ~outValid | down_ready;

    // The assembly word with the incoming byte already placed in lane cnt.
    assign doneData = DW'(lane_write(MAX_W'(asmData), int'(cnt_q), up_data));
    assign doneKeep = BYTES'(keep_mask(int'(cnt_q)));

    // Lane counter: advances per accepted byte, restarts when a word closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next lane for the following byte.
    always_comb begin
        cnt_d = cnt_q;
        if (wordDone) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Assembly slot control: accumulate lanes, park a finished word when the
    // output is stalled, and empty once its contents move downstream.
    always_comb begin
        asmLoad    = 1'b0;
        asmClear   = 1'b0;
        asmValidIn = 1'b0;
        asmLastIn  = 1'b0;
        if (asmFull && outFree) begin
            asmClear = 1'b1;
        end else if (wordDone && outFree) begin
            asmClear = 1'b1;
        end else if (wordDone) begin
            asmLoad    = 1'b1;
            asmValidIn = 1'b1;
            asmLastIn  = up_last;
        end else if (accept) begin
            asmLoad = 1'b1;
        end
    end

    // Output slot control: take a parked word first, otherwise the word that
    // closes this cycle; a plain handshake just drops valid.
    always_comb begin
        outLoad   = 1'b0;
        outDataIn = doneData;
        outKeepIn = doneKeep;
        outLastIn = up_last;
        if (asmFull && outFree) begin
            outLoad   = 1'b1;
            outDataIn = asmData;
            outKeepIn = asmKeep;
            outLastIn = asmLast;
        end else if (wordDone && outFree) begin
            outLoad = 1'b1;
        end
        outDrain = outValid & down_ready;
    end

    word_slot #(.LANES(BYTES)) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (asmLoad),
        .clear_i (asmClear),
        .drain_i (1'b0),
        .data_i  (doneData),
        .keep_i  (doneKeep),
        .last_i  (asmLastIn),
        .valid_i (asmValidIn),
        .data_o  (asmData),
        .keep_o  (asmKeep),
        .last_o  (asmLast),
        .valid_o (asmFull)
    );

    word_slot #(.LANES(BYTES)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (outLoad),
        .clear_i (1'b0),
        .drain_i (outDrain),
        .data_i  (outDataIn),
        .keep_i  (outKeepIn),
        .last_i  (outLastIn),
        .valid_i (1'b1),
        .data_o  (down_data),
        .keep_o  (down_keep),
        .last_o  (down_last),
        .valid_o (outValid)
    );

    assign down_valid = outValid;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed scenarios plus a randomized stream, all
// checked against a word-list model of the packing rules.
module tb_byte_packer;

    localparam int BYTES = 4;
    localparam int DW    = 8 * BYTES;

    typedef struct {
        logic [DW-1:0]    data;
        logic [BYTES-1:0] keep;
        logic             last;
    } word_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic [7:0]       upData;
    logic             upValid;
    logic             upLast;
    logic             upReady;
    logic [DW-1:0]    downData;
    logic [BYTES-1:0] downKeep;
    logic             downLast;
    logic             downValid;
    logic             downReady;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Words completed but not yet delivered, oldest first.
    word_t expQ[$];
    word_t seenQ[$];
    int    seenCyc[$];
    word_t monWord;
    logic [DW-1:0] partData = '0;
    int    partCnt = 0;
    bit    senderDone;

    always #5 clk = ~clk;

    byte_packer #(.BYTES(BYTES)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .up_data    (upData),
        .up_valid   (upValid),
        .up_last    (upLast),
        .up_ready   (upReady),
        .down_data  (downData),
        .down_keep  (downKeep),
        .down_last  (downLast),
        .down_valid (downValid),
        .down_ready (downReady)
    );

    // Count a comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one byte and hold it until the packer takes it.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        upData  = b;
        upLast  = last;
        upValid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (upReady) break;
            if (n >= 100) begin
                checkOutput("up_ready_timeout", 128'd0, 128'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        upValid = 1'b0;
        upLast  = 1'b0;
    endtask

    // Wait until every completed word has been delivered.
    task automatic waitDrain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) return;
        end
        checkOutput("drain_timeout", 128'(expQ.size()), 128'd0);
    endtask

    task automatic clearSeen();
        seenQ.delete();
        seenCyc.delete();
    endtask

    // Model and monitor: sampled mid-cycle, decides the handshakes that the
    // next rising edge will perform and checks the port state against the
    // number of undelivered words.
    always @(negedge clk) begin
        cycle++;
        if (!rstN) begin
            expQ.delete();
            partData = '0;
            partCnt  = 0;
            checkOutput("rst_down_valid", 128'(downValid), 128'd0);
            checkOutput("rst_up_ready", 128'(upReady), 128'd1);
            checkOutput("rst_down_data", 128'(downData), 128'd0);
            checkOutput("rst_down_keep", 128'(downKeep), 128'd0);
            checkOutput("rst_down_last", 128'(downLast), 128'd0);
        end else begin
            checkOutput("up_ready", 128'(upReady), 128'(expQ.size() < 2));
            checkOutput("down_valid", 128'(downValid), 128'(expQ.size() != 0));
            if (downValid && downReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", 128'(downData), 128'd0);
                end else begin
                    monWord = expQ.pop_front();
                    checkOutput("word_data", 128'(downData), 128'(monWord.data));
                    checkOutput("word_keep", 128'(downKeep), 128'(monWord.keep));
                    checkOutput("word_last", 128'(downLast), 128'(monWord.last));
                end
                seenQ.push_back('{data: downData, keep: downKeep, last: downLast});
                seenCyc.push_back(cycle);
            end
            if (upValid && upReady) begin
                partData[partCnt*8 +: 8] = upData;
                partCnt++;
                if (partCnt == BYTES || upLast) begin
                    expQ.push_back('{data: partData,
                                     keep: BYTES'((1 << partCnt) - 1),
                                     last: upLast});
                    partData = '0;
                    partCnt  = 0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized stream.
    initial begin
        rstN      = 1'b0;
        upData    = 8'h00;
        upValid   = 1'b0;
        upLast    = 1'b0;
        downReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Full word, no last.
        $display("[TB] case 1: full word");
        downReady = 1'b1;
        clearSeen();
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        waitDrain(20);
        checkOutput("c1_count", 128'(seenQ.size()), 128'd1);
        if (seenQ.size() >= 1) begin
            checkOutput("c1_data", 128'(seenQ[0].data), 128'h44332211);
            checkOutput("c1_keep", 128'(seenQ[0].keep), 128'hF);
            checkOutput("c1_last", 128'(seenQ[0].last), 128'd0);
        end

        // Short word with last, then a full word restarting at lane 0.
        $display("[TB] case 2: short word");
        clearSeen();
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(8'hB0 + 8'(i), 1'b0);
        waitDrain(20);
        checkOutput("c2_count", 128'(seenQ.size()), 128'd2);
        if (seenQ.size() >= 2) begin
            checkOutput("c2_data0", 128'(seenQ[0].data), 128'h0000A2A1);
            checkOutput("c2_keep0", 128'(seenQ[0].keep), 128'h3);
            checkOutput("c2_last0", 128'(seenQ[0].last), 128'd1);
            checkOutput("c2_data1", 128'(seenQ[1].data), 128'hB4B3B2B1);
            checkOutput("c2_keep1", 128'(seenQ[1].keep), 128'hF);
        end

        // Backpressure: two words buffered, then released back to back.
        $display("[TB] case 3: backpressure");
        downReady = 1'b0;
        clearSeen();
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("c3_up_ready_low", 128'(upReady), 128'd0);
        checkOutput("c3_held_data", 128'(downData), 128'h04030201);
        checkOutput("c3_held_valid", 128'(downValid), 128'd1);
        downReady = 1'b1;
        waitDrain(20);
        checkOutput("c3_count", 128'(seenQ.size()), 128'd2);
        if (seenQ.size() >= 2) begin
            checkOutput("c3_data0", 128'(seenQ[0].data), 128'h04030201);
            checkOutput("c3_data1", 128'(seenQ[1].data), 128'h08070605);
            checkOutput("c3_gap", 128'(seenCyc[1] - seenCyc[0]), 128'd1);
        end

        // Back-to-back streaming with no bubbles.
        $display("[TB] case 4: streaming");
        clearSeen();
        for (int i = 0; i < 12; i++) applyStimulus(8'(i), 1'b0);
        waitDrain(20);
        checkOutput("c4_count", 128'(seenQ.size()), 128'd3);
        if (seenQ.size() >= 3) begin
            checkOutput("c4_data0", 128'(seenQ[0].data), 128'h03020100);
            checkOutput("c4_data1", 128'(seenQ[1].data), 128'h07060504);
            checkOutput("c4_data2", 128'(seenQ[2].data), 128'h0B0A0908);
            checkOutput("c4_gap0", 128'(seenCyc[1] - seenCyc[0]), 128'd4);
            checkOutput("c4_gap1", 128'(seenCyc[2] - seenCyc[1]), 128'd4);
        end

        // Reset in the middle of a word.
        $display("[TB] case 5: mid-word reset");
        applyStimulus(8'hEE, 1'b0);
        applyStimulus(8'hEF, 1'b0);
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("c5_rst_valid", 128'(downValid), 128'd0);
        checkOutput("c5_rst_ready", 128'(upReady), 128'd1);
        checkOutput("c5_rst_data", 128'(downData), 128'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        clearSeen();
        for (int i = 0; i < 4; i++) applyStimulus(8'h55 + 8'(i), 1'b0);
        waitDrain(20);
        checkOutput("c5_count", 128'(seenQ.size()), 128'd1);
        if (seenQ.size() >= 1) begin
            checkOutput("c5_data", 128'(seenQ[0].data), 128'h58575655);
            checkOutput("c5_keep", 128'(seenQ[0].keep), 128'hF);
        end

        // Single-byte last word queued behind a stalled output word.
        $display("[TB] case 6: single byte behind stall");
        downReady = 1'b0;
        clearSeen();
        for (int i = 1; i <= 4; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
        applyStimulus(8'h7C, 1'b1);
        checkOutput("c6_up_ready_low", 128'(upReady), 128'd0);
        downReady = 1'b1;
        waitDrain(20);
        checkOutput("c6_count", 128'(seenQ.size()), 128'd2);
        if (seenQ.size() >= 2) begin
            checkOutput("c6_data", 128'(seenQ[1].data), 128'h0000007C);
            checkOutput("c6_keep", 128'(seenQ[1].keep), 128'h1);
            checkOutput("c6_last", 128'(seenQ[1].last), 128'd1);
        end

        // Random bytes, gaps, lasts and downstream backpressure.
        $display("[TB] random stream");
        senderDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    applyStimulus(8'($urandom), $urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                senderDone = 1'b1;
            end
            begin
                while (!senderDone) begin
                    @(posedge clk);
                    #1;
                    downReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        downReady = 1'b1;
        waitDrain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
